// File: rtl/cpu_defs_pkg.sv
// Shared CPU types: TLB op encodings, TLB entry layout and TLB index width.
package cpu_defs;

  typedef enum logic [1:0] {
    TLB_OP_TLBR  = 2'd0,
    TLB_OP_TLBWI = 2'd1,
    TLB_OP_TLBWR = 2'd2,
    TLB_OP_TLBP  = 2'd3
  } tlb_op_t;

  typedef logic [3:0] tlb_index_t;

  typedef struct packed {
    logic [31:0] entry_hi;
    logic [31:0] entry_lo0;
    logic [31:0] entry_lo1;
    logic [31:0] page_mask;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_random_reg.sv
// CP0 Random: free-running down-counter over [wired+1 .. TLB_ENTRIES-1], reloaded to the top on wrap or Wired write.
module tlb_random_reg #(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wired_we,
  input  logic [IDX_W-1:0] cp0_wired,
  output logic [IDX_W-1:0] random
);

  localparam logic [IDX_W-1:0] RAND_MAX = IDX_W'(TLB_ENTRIES - 1);

  logic [IDX_W-1:0] dec;
  logic             wrap;

  assign dec = random - IDX_W'(1);
  // A Wired value at or above the top keeps dec <= wired true, pinning Random at RAND_MAX.
  assign wrap = (random == '0) || (dec <= cp0_wired);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random <= RAND_MAX;
    end else if (wired_we || wrap) begin
      random <= RAND_MAX;
    end else begin
      random <= dec;
    end
  end

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLBR/TLBWI/TLBWR/TLBP onto the MMU port: accept N, strobe N+1, done N+3; one op in flight, op_ready only in IDLE.
// Optional CPU_TLB_ITLB_FLUSH_EN adds itlb_flush, pulsed in CAPTURE after a committed TLB write.
module tlb_op_sequencer
  import cpu_defs::*;
#(
  parameter int TLB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [1:0]       op_type,
  output logic             op_ready,
  input  logic             flush,
  input  logic [IDX_W-1:0] cp0_index,
  input  logic [IDX_W-1:0] cp0_wired,
  input  logic             wired_we,
  input  logic [31:0]      cp0_entry_hi,
  input  tlb_entry_t       cp0_wdata,
  output logic [IDX_W-1:0] tlbrw_index,
  output logic             tlbrw_we,
  output tlb_entry_t       tlbrw_wdata,
  input  tlb_entry_t       tlbrw_rdata,
  output logic [31:0]      tlbp_entry_hi,
  input  logic [31:0]      tlbp_index,
  output logic             done_valid,
  output logic [1:0]       done_op,
  output tlb_entry_t       done_rdata,
  output logic [31:0]      done_index,
  output logic [IDX_W-1:0] cp0_random
`ifdef CPU_TLB_ITLB_FLUSH_EN
  ,
  output logic             itlb_flush
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_DONE} state_t;

  state_t           state, state_nxt;
  tlb_op_t          op_q;
  logic [IDX_W-1:0] idx_q;
  tlb_entry_t       wdata_q;
  logic [31:0]      ehi_q;
  logic             accept;
  logic             is_write;

  tlb_random_reg #(.TLB_ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_random (
    .clk       (clk),
    .rst_n     (rst_n),
    .wired_we  (wired_we),
    .cp0_wired (cp0_wired),
    .random    (cp0_random)
  );

  assign accept   = op_valid && op_ready && !flush;
  assign is_write = (op_q == TLB_OP_TLBWI) || (op_q == TLB_OP_TLBWR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    op_ready   = 1'b0;
    tlbrw_we   = 1'b0;
    done_valid = 1'b0;
`ifdef CPU_TLB_ITLB_FLUSH_EN
    itlb_flush = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        op_ready = 1'b1;
        if (accept) state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        // A flush here kills the op before the MMU sees a write strobe.
        tlbrw_we  = is_write && !flush;
        state_nxt = flush ? S_IDLE : S_CAPTURE;
      end
      S_CAPTURE: begin
`ifdef CPU_TLB_ITLB_FLUSH_EN
        itlb_flush = is_write;
`endif
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done_valid = 1'b1;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latches keep the MMU ports stable from ISSUE through CAPTURE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= TLB_OP_TLBR;
      idx_q   <= '0;
      wdata_q <= '0;
      ehi_q   <= '0;
    end else if (accept) begin
      op_q    <= tlb_op_t'(op_type);
      idx_q   <= (op_type == TLB_OP_TLBWR) ? cp0_random : cp0_index;
      wdata_q <= cp0_wdata;
      ehi_q   <= cp0_entry_hi;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_rdata <= '0;
      done_index <= '0;
    end else if (state == S_CAPTURE) begin
      if (op_q == TLB_OP_TLBR) done_rdata <= tlbrw_rdata;
      if (op_q == TLB_OP_TLBP) done_index <= tlbp_index;
    end
  end

  assign tlbrw_index   = idx_q;
  assign tlbrw_wdata   = wdata_q;
  assign tlbp_entry_hi = ehi_q;
  assign done_op       = op_q;

endmodule
